pgm_rcv: RTL
============

PGM_RCV -- requirements
Module: pgm_rcv

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of every statistics counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have ports in_rcv_data_wr (input, 1) and in_rcv_data (input, 134) carrying the packet beat. Bits [133:132] are the beat type: 01 head, 11 middle, 10 tail. Bits [131:128] are the count of invalid bytes in a tail beat. Bits [127:0] are payload.
REQ-005 The block SHALL have ports in_rcv_valid_wr (input, 1) and in_rcv_valid (input, 1): the end-of-packet valid strobe and the packet keep(1)/drop(0) indication.
REQ-006 The block SHALL have ports in_rcv_phv (input, 1024) and in_rcv_phv_wr (input, 1): the metadata word, one per packet.
REQ-007 The block SHALL have outputs out_rcv_alf and out_rcv_phv_alf (1 each): almost-full back-pressure toward the generator.
REQ-008 The block SHALL have inputs in_rcv_start_flag and in_rcv_finish_flag (1 each): generator run-start and run-finish pulses.
REQ-009 The block SHALL have outputs out_rcv_pkt_cnt, out_rcv_byte_cnt, out_rcv_phv_cnt, out_rcv_drop_cnt and out_rcv_cycle_cnt, each CNT_W bits: run statistics.
REQ-010 The block SHALL have outputs out_rcv_err (1): sticky framing error; out_rcv_busy (1): run in progress; out_rcv_done (1): one-cycle pulse at run end.

Function
REQ-011 The run FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on in_rcv_start_flag.
- RUN->DONE on in_rcv_finish_flag.
- DONE->IDLE after one cycle.
REQ-012 Entering RUN SHALL clear all counters and out_rcv_err in the same edge. A start flag while in RUN SHALL restart the run (counters cleared, state stays RUN).
REQ-013 Start and finish asserted in the same cycle SHALL act as a start only.
REQ-014 out_rcv_busy SHALL be 1 exactly while in RUN. out_rcv_done SHALL be 1 exactly while in DONE.
REQ-015 Beats, phv writes and valid strobes outside RUN SHALL be consumed and ignored; no counter changes.
REQ-016 The frame FSM SHALL have states WAIT_HEAD and IN_PKT.
- A head beat moves WAIT_HEAD->IN_PKT.
- A tail beat moves IN_PKT->WAIT_HEAD.
- A single beat with type 10 while in WAIT_HEAD is illegal.
REQ-017 The following SHALL set out_rcv_err; the frame FSM then resynchronises to the offending beat (a head enters IN_PKT, anything else goes to WAIT_HEAD):
- a head beat in IN_PKT;
- a middle or tail beat in WAIT_HEAD;
- type 00.
REQ-018 out_rcv_byte_cnt SHALL add 16 per head/middle beat and (16 - data[131:128]) per tail beat, with the subtraction done in 5 bits.
REQ-019 Each in_rcv_valid_wr SHALL increment out_rcv_pkt_cnt if in_rcv_valid=1, else out_rcv_drop_cnt. Each in_rcv_phv_wr SHALL increment out_rcv_phv_cnt.
REQ-020 All counters SHALL saturate at all-ones and never wrap.
REQ-021 All statistics outputs SHALL be registered, reflecting an input event one cycle after it is sampled. Counters SHALL hold their values through DONE and IDLE until the next start.
REQ-022 out_rcv_alf and out_rcv_phv_alf SHALL be held 0, since the block sinks one beat and one phv every cycle without stalling.

Reset
REQ-023 With rst_n=0 at a clock edge, the following SHALL happen at that edge:
- run FSM to IDLE, frame FSM to WAIT_HEAD;
- all counters to 0;
- out_rcv_err, out_rcv_busy and out_rcv_done to 0.
REQ-024 Reset asserted mid-run or mid-packet SHALL abandon the run with no done pulse. The first beat after reset release SHALL be checked from WAIT_HEAD.

Configuration
REQ-025 Macro PGM_RCV_CYCLE_CNT_EN:
- Defined: out_rcv_cycle_cnt SHALL count clock cycles spent in RUN, from 1 on the first RUN cycle up to the cycle that samples finish, saturating at all-ones.
- Undefined: out_rcv_cycle_cnt SHALL be constant 0 and no cycle counter SHALL be synthesised.

Verification
REQ-026 Start; 3 packets of 4 beats each (head, 2 mid, tail with [131:128]=6), valid=1, 3 phv writes; finish. Required: pkt=3, byte=174, phv=3, drop=0, err=0, done pulses once.
REQ-027 Start; 2 packets, one with valid=0. Required: pkt=1, drop=1.
REQ-028 Start; middle beat with no head, then a legal head+tail packet. Required: err=1 and stays 1; the legal packet's bytes are still counted.
REQ-029 Start and finish in the same cycle. Required: state RUN, counters 0, no done. A later start mid-run clears counters.
REQ-030 With CNT_W=4, send 20 single-packet runs within one RUN. Required: pkt_cnt=15, saturated.
REQ-031 rst_n=0 mid-packet, then a tail beat. Required: err=1 after restart via start. With PGM_RCV_CYCLE_CNT_EN defined, a 100-cycle run gives cycle=100; undefined gives 0.

Source files
------------

// File: rtl/pgm_rcv.sv
// pgm_rcv: packet-generator receive sink; checks beat framing and gathers run statistics.
// Latency: every statistics output is registered and reflects a sampled input event one cycle later.
// Backpressure: none; one beat and one phv are sunk every cycle, so out_rcv_alf/out_rcv_phv_alf stay 0.
//
// Ports:
//   clk, rst_n                        single clock, synchronous active-low reset
//   in_rcv_data_wr/in_rcv_data        beat strobe + 134-bit beat {type[1:0], invalid_bytes[3:0], payload[127:0]}
//   in_rcv_valid_wr/in_rcv_valid      end-of-packet strobe + keep(1)/drop(0)
//   in_rcv_phv_wr/in_rcv_phv          per-packet metadata word (only counted)
//   in_rcv_start_flag/finish_flag     run start / run finish pulses
//   out_rcv_*_cnt                     saturating run statistics, CNT_W bits
//   out_rcv_err/busy/done             sticky framing error, run active, one-cycle end-of-run pulse
// Build option: define PGM_RCV_CYCLE_CNT_EN to include the RUN cycle counter;
// otherwise out_rcv_cycle_cnt is tied to 0.
module pgm_rcv #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_rcv_data_wr,
  input  logic [133:0]     in_rcv_data,
  input  logic             in_rcv_valid_wr,
  input  logic             in_rcv_valid,
  input  logic [1023:0]    in_rcv_phv,
  input  logic             in_rcv_phv_wr,
  output logic             out_rcv_alf,
  output logic             out_rcv_phv_alf,
  input  logic             in_rcv_start_flag,
  input  logic             in_rcv_finish_flag,
  output logic [CNT_W-1:0] out_rcv_pkt_cnt,
  output logic [CNT_W-1:0] out_rcv_byte_cnt,
  output logic [CNT_W-1:0] out_rcv_phv_cnt,
  output logic [CNT_W-1:0] out_rcv_drop_cnt,
  output logic [CNT_W-1:0] out_rcv_cycle_cnt,
  output logic             out_rcv_err,
  output logic             out_rcv_busy,
  output logic             out_rcv_done
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic F_WAIT_HEAD = 1'b0;
  localparam logic F_IN_PKT    = 1'b1;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_MID  = 2'b11;
  localparam logic [1:0] T_TAIL = 2'b10;

  // Byte sum is widened so that adding up to 16 never loses the carry, even for tiny CNT_W.
  localparam int SW = CNT_W + 5;

  logic [1:0]       r_run_st;
  logic             r_frm_st;
  logic             r_err;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [CNT_W-1:0] r_phv_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_clr;
  logic             w_cnt_en;
  logic             w_frm_nxt;
  logic             w_frm_err;
  logic [4:0]       w_byte_inc;
  logic [SW-1:0]    w_byte_sum;
  logic [CNT_W-1:0] w_byte_nxt;
  logic             w_unused;

  // Payload and phv contents are only consumed, never inspected.
  assign w_unused = ^{in_rcv_data[127:0], in_rcv_phv};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  // A start in IDLE or RUN (re)enters RUN and wins over finish and over any same-cycle event.
  assign w_clr    = in_rcv_start_flag && (r_run_st != S_DONE);
  assign w_cnt_en = (r_run_st == S_RUN) && !in_rcv_start_flag;

  // Frame checker. Only beats that belong to a packet are counted: a head always starts
  // a packet (including the resync case), orphan middles/tails and type 00 are dropped.
  always_comb begin
    w_frm_nxt  = r_frm_st;
    w_frm_err  = 1'b0;
    w_byte_inc = 5'd0;
    if (in_rcv_data_wr) begin
      case (in_rcv_data[133:132])
        T_HEAD: begin
          w_frm_err  = (r_frm_st == F_IN_PKT);
          w_frm_nxt  = F_IN_PKT;
          w_byte_inc = 5'd16;
        end
        T_MID: begin
          if (r_frm_st == F_IN_PKT) w_byte_inc = 5'd16;
          else                      w_frm_err  = 1'b1;
        end
        T_TAIL: begin
          if (r_frm_st == F_IN_PKT) begin
            w_byte_inc = 5'd16 - {1'b0, in_rcv_data[131:128]};
            w_frm_nxt  = F_WAIT_HEAD;
          end else begin
            w_frm_err  = 1'b1;
          end
        end
        default: begin
          w_frm_err = 1'b1;
          w_frm_nxt = F_WAIT_HEAD;
        end
      endcase
    end
  end

  assign w_byte_sum = SW'(r_byte_cnt) + SW'(w_byte_inc);
  assign w_byte_nxt = (w_byte_sum[SW-1:CNT_W] != '0) ? {CNT_W{1'b1}} : w_byte_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run_st   <= S_IDLE;
      r_frm_st   <= F_WAIT_HEAD;
      r_err      <= 1'b0;
      r_pkt_cnt  <= '0;
      r_byte_cnt <= '0;
      r_phv_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      case (r_run_st)
        S_IDLE:  if (in_rcv_start_flag) r_run_st <= S_RUN;
        S_RUN:   if (!in_rcv_start_flag && in_rcv_finish_flag) r_run_st <= S_DONE;
        default: r_run_st <= S_IDLE;
      endcase

      if (w_clr) begin
        r_frm_st   <= F_WAIT_HEAD;
        r_err      <= 1'b0;
        r_pkt_cnt  <= '0;
        r_byte_cnt <= '0;
        r_phv_cnt  <= '0;
        r_drop_cnt <= '0;
      end else if (w_cnt_en) begin
        r_frm_st   <= w_frm_nxt;
        r_err      <= r_err | w_frm_err;
        r_byte_cnt <= w_byte_nxt;
        r_pkt_cnt  <= sat_inc(r_pkt_cnt,  in_rcv_valid_wr &&  in_rcv_valid);
        r_drop_cnt <= sat_inc(r_drop_cnt, in_rcv_valid_wr && !in_rcv_valid);
        r_phv_cnt  <= sat_inc(r_phv_cnt,  in_rcv_phv_wr);
      end
    end
  end

`ifdef PGM_RCV_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  // Counts every RUN cycle that is not a restart, so the finish cycle is included.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_cycle_cnt <= '0;
    else if (w_clr)    r_cycle_cnt <= '0;
    else if (w_cnt_en) r_cycle_cnt <= sat_inc(r_cycle_cnt, 1'b1);
  end

  assign out_rcv_cycle_cnt = r_cycle_cnt;
`else
  assign out_rcv_cycle_cnt = '0;
`endif

  assign out_rcv_alf      = 1'b0;
  assign out_rcv_phv_alf  = 1'b0;
  assign out_rcv_pkt_cnt  = r_pkt_cnt;
  assign out_rcv_byte_cnt = r_byte_cnt;
  assign out_rcv_phv_cnt  = r_phv_cnt;
  assign out_rcv_drop_cnt = r_drop_cnt;
  assign out_rcv_err      = r_err;
  assign out_rcv_busy     = (r_run_st == S_RUN);
  assign out_rcv_done     = (r_run_st == S_DONE);

endmodule
